// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback and the multiply/divide unit (MDU). The pipeline has priority.
//   MDU results queue in a small FIFO and drain into idle write slots. If the
//   FIFO stays undrained for STARVE_MAX consecutive cycles, the pipeline is
//   stalled for one cycle so that the head entry can be written.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   pipe_we/pipe_rd/pipe_data    pipeline writeback request (x0 writes dropped)
//   pipe_stall                   pipeline must hold its writeback this cycle
//   mdu_valid/mdu_rd/mdu_data    MDU result offer (held until accepted)
//   mdu_ready                    FIFO can accept an MDU result this cycle
//   rf_we/rf_waddr/rf_wdata      registered register-file write port
//   busy_mask                    bit i set while a queued entry targets x[i]
module wb_port_arbiter #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_we,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_data,
   output logic            pipe_stall,
   input  logic            mdu_valid,
   input  logic [4:0]      mdu_rd,
   input  logic [XLEN-1:0] mdu_data,
   output logic            mdu_ready,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     busy_mask
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [4:0]      ent_rd_q   [DEPTH];
   logic [4:0]      ent_rd_d   [DEPTH];
   logic [XLEN-1:0] ent_data_q [DEPTH];
   logic [XLEN-1:0] ent_data_d [DEPTH];
   logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

   logic            empty;
   logic            full;
   logic [AW:0]     count;
   logic [AW-1:0]   head_idx;
   logic [AW-1:0]   tail_idx;
   logic [AW-1:0]   slot_off;
   logic            pipe_req;
   logic            starved;
   logic            drain;
   logic            enq;
   logic [31:0]     busy_c;

   always_comb begin
      empty    = (rd_ptr_q == wr_ptr_q);
      full     = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
      count    = wr_ptr_q - rd_ptr_q;
      head_idx = rd_ptr_q[AW-1:0];
      tail_idx = wr_ptr_q[AW-1:0];
      pipe_req = pipe_we && (pipe_rd != 5'd0);
      starved  = (starve_cnt_q == CNT_MAX);
      drain    = !empty && (!pipe_req || starved);

      // Readiness comes from registered occupancy only, so a same-cycle
      // dequeue never opens a slot in a full FIFO.
      mdu_ready  = !full && !rst;
      pipe_stall = drain && pipe_req && !rst;
      // Results for x0 complete the handshake but are never queued.
      enq        = mdu_valid && mdu_ready && (mdu_rd != 5'd0);

      // A slot is occupied when its distance from the head is below count.
      busy_c   = '0;
      slot_off = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         slot_off = AW'(i) - head_idx;
         if ({1'b0, slot_off} < count) begin
            busy_c[ent_rd_q[AW'(i)]] = 1'b1;
         end
      end
      busy_c[0] = 1'b0;
      busy_mask = rst ? '0 : busy_c;
   end

   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      ent_rd_d     = ent_rd_q;
      ent_data_d   = ent_data_q;
      starve_cnt_d = starve_cnt_q;
      rf_we_d      = 1'b0;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;

      if (drain) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = ent_rd_q[head_idx];
         rf_wdata_d = ent_data_q[head_idx];
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end else if (pipe_req) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = pipe_rd;
         rf_wdata_d = pipe_data;
      end

      if (enq) begin
         ent_rd_d[tail_idx]   = mdu_rd;
         ent_data_d[tail_idx] = mdu_data;
         wr_ptr_d             = wr_ptr_q + PTR_ONE;
      end

      if (empty || drain) begin
         starve_cnt_d = '0;
      end else if (!starved) begin
         starve_cnt_d = starve_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         starve_cnt_q <= '0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
      end
   end

   // Entry storage is qualified by the pointers and needs no reset.
   always_ff @(posedge clk) begin
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int XLEN       = 32;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            pipe_we;
   logic [4:0]      pipe_rd;
   logic [XLEN-1:0] pipe_data;
   logic            pipe_stall;
   logic            mdu_valid;
   logic [4:0]      mdu_rd;
   logic [XLEN-1:0] mdu_data;
   logic            mdu_ready;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [31:0]     busy_mask;

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .XLEN(XLEN),
      .DEPTH(DEPTH),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pipe_we(pipe_we),
      .pipe_rd(pipe_rd),
      .pipe_data(pipe_data),
      .pipe_stall(pipe_stall),
      .mdu_valid(mdu_valid),
      .mdu_rd(mdu_rd),
      .mdu_data(mdu_data),
      .mdu_ready(mdu_ready),
      .rf_we(rf_we),
      .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata),
      .busy_mask(busy_mask)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        pwe;
      logic [4:0]  prd;
      logic [31:0] pdat;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] mdat;
      logic        es;
      logic        er;
      logic [31:0] eb;
      logic        ewe;
      logic [4:0]  ea;
      logic [31:0] ed;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   vec_t tbl[9];

   // Reference model state: FIFO contents as a queue, cycles waited, and
   // the expected register-file port.
   ent_t        mq[$];
   int          waited;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, check combinational outputs mid-cycle and
   // the registered write port just after the rising edge.
   task automatic cyc(input string name,
                      input logic pwe, input logic [4:0] prd, input logic [31:0] pdat,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic es, input logic er, input logic [31:0] eb,
                      input logic ewe, input logic [4:0] ea, input logic [31:0] ed);
      pipe_we   = pwe;
      pipe_rd   = prd;
      pipe_data = pdat;
      mdu_valid = mv;
      mdu_rd    = mrd;
      mdu_data  = mdat;
      @(negedge clk);
      chk({name, " pipe_stall"}, 32'(pipe_stall), 32'(es));
      chk({name, " mdu_ready"}, 32'(mdu_ready), 32'(er));
      chk({name, " busy_mask"}, busy_mask, eb);
      @(posedge clk);
      #1;
      chk({name, " rf_we"}, 32'(rf_we), 32'(ewe));
      chk({name, " rf_waddr"}, 32'(rf_waddr), 32'(ea));
      chk({name, " rf_wdata"}, rf_wdata, ed);
   endtask

   initial begin
      logic        p_we, p_hold, m_v, m_acc, do_rst, conflict;
      logic [4:0]  p_rd, m_rd, r;
      logic [31:0] p_dat, m_dat, eb;
      logic        es, er, preq, drain, was_empty;

      rst = 1'b1;
      pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
      mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      //          pwe   prd    pdat          mv    mrd    mdat          es    er    eb            ewe   ea     ed
      tbl[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 5'd0,  32'h0};
      tbl[1] = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 5'd5,  32'h1234};
      tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hDEAD,     1'b0, 1'b1, 32'h0,        1'b0, 5'd5,  32'h1234};
      tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h80,       1'b1, 5'd7,  32'hDEAD};
      tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 5'd7,  32'hDEAD};
      tbl[5] = '{1'b1, 5'd0,  32'h5555,     1'b1, 5'd0,  32'h6666,     1'b0, 1'b1, 32'h0,        1'b0, 5'd7,  32'hDEAD};
      tbl[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 5'd7,  32'hDEAD};
      tbl[7] = '{1'b0, 5'd3,  32'h7777,     1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 5'd7,  32'hDEAD};
      tbl[8] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 5'd31, 32'hFFFFFFFF};

      for (int i = 0; i < 9; i++) begin
         cyc($sformatf("tbl%0d", i), tbl[i].pwe, tbl[i].prd, tbl[i].pdat, tbl[i].mv, tbl[i].mrd,
             tbl[i].mdat, tbl[i].es, tbl[i].er, tbl[i].eb, tbl[i].ewe, tbl[i].ea, tbl[i].ed);
      end

      // Starvation: rd=9 queued, then continuous pipeline writes rd=1..5.
      cyc("starve0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999, 1'b0, 1'b1, 32'h0, 1'b0, 5'd31, 32'hFFFFFFFF);
      for (int k = 1; k <= 4; k++) begin
         cyc($sformatf("starve%0d", k), 1'b1, 5'(k), 32'h100 + 32'(k), 1'b0, 5'd0, 32'h0,
             1'b0, 1'b1, 32'h200, 1'b1, 5'(k), 32'h100 + 32'(k));
      end
      cyc("starve5", 1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1, 5'd9, 32'h9999);
      cyc("starve6", 1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0,   1'b1, 5'd5, 32'h105);
      cyc("starve7", 1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0,   1'b0, 5'd5, 32'h105);

      // Three MDU results under continuous pipeline traffic; FIFO fills.
      cyc("full0",  1'b1, 5'd20, 32'h200, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b1, 32'h0,    1'b1, 5'd20, 32'h200);
      cyc("full1",  1'b1, 5'd21, 32'h201, 1'b1, 5'd11, 32'hB0, 1'b0, 1'b1, 32'h400,  1'b1, 5'd21, 32'h201);
      cyc("full2",  1'b1, 5'd22, 32'h202, 1'b1, 5'd12, 32'hC0, 1'b0, 1'b0, 32'hC00,  1'b1, 5'd22, 32'h202);
      cyc("full3",  1'b1, 5'd23, 32'h203, 1'b1, 5'd12, 32'hC0, 1'b0, 1'b0, 32'hC00,  1'b1, 5'd23, 32'h203);
      cyc("full4",  1'b1, 5'd24, 32'h204, 1'b1, 5'd12, 32'hC0, 1'b0, 1'b0, 32'hC00,  1'b1, 5'd24, 32'h204);
      cyc("full5",  1'b1, 5'd25, 32'h205, 1'b1, 5'd12, 32'hC0, 1'b1, 1'b0, 32'hC00,  1'b1, 5'd10, 32'hA0);
      cyc("full6",  1'b1, 5'd25, 32'h205, 1'b1, 5'd12, 32'hC0, 1'b0, 1'b1, 32'h800,  1'b1, 5'd25, 32'h205);
      cyc("full7",  1'b1, 5'd26, 32'h206, 1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 32'h1800, 1'b1, 5'd26, 32'h206);
      cyc("full8",  1'b1, 5'd27, 32'h207, 1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 32'h1800, 1'b1, 5'd27, 32'h207);
      cyc("full9",  1'b1, 5'd28, 32'h208, 1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 32'h1800, 1'b1, 5'd28, 32'h208);
      cyc("full10", 1'b1, 5'd29, 32'h209, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 32'h1800, 1'b1, 5'd11, 32'hB0);
      cyc("full11", 1'b1, 5'd29, 32'h209, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 32'h1000, 1'b1, 5'd29, 32'h209);
      cyc("full12", 1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 32'h1000, 1'b1, 5'd12, 32'hC0);
      cyc("full13", 1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 32'h0,    1'b0, 5'd12, 32'hC0);

      // Reset with two entries queued.
      cyc("rst0", 1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD0, 1'b0, 1'b1, 32'h0,    1'b1, 5'd1, 32'h1);
      cyc("rst1", 1'b1, 5'd2, 32'h2, 1'b1, 5'd14, 32'hE0, 1'b0, 1'b1, 32'h2000, 1'b1, 5'd2, 32'h2);
      rst = 1'b1;
      cyc("rst2", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0);
      rst = 1'b0;
      cyc("rst3", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 32'h0,    1'b0, 5'd0, 32'h0);
      cyc("rst4", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 32'h0,    1'b0, 5'd0, 32'h0);

      // Randomised traffic against the queue-based reference model.
      mq.delete();
      waited = 0;
      m_we = 1'b0; m_addr = '0; m_data = '0;
      p_we = 1'b0; p_rd = '0; p_dat = '0; p_hold = 1'b0;
      m_v = 1'b0; m_rd = '0; m_dat = '0; m_acc = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         do_rst = ($urandom_range(0, 299) == 0);
         if (!p_hold) begin
            p_we = ($urandom_range(0, 99) < 85);
            p_rd = 5'd0;
            // Issue-stage hazard contract: never target a queued or in-flight MDU rd.
            for (int t = 0; t < 20; t++) begin
               r = 5'($urandom_range(0, 31));
               conflict = m_v && (m_rd == r) && (r != 5'd0);
               foreach (mq[k]) if (mq[k].rd == r) conflict = 1'b1;
               if (!conflict) begin
                  p_rd = r;
                  break;
               end
            end
            p_dat = $urandom;
         end
         if (!m_v || m_acc) begin
            m_v  = ($urandom_range(0, 99) < 30);
            m_rd = 5'($urandom_range(0, 31));
            if (p_we && m_rd == p_rd) m_rd = 5'd0;
            m_dat = $urandom;
         end

         rst = do_rst;
         if (do_rst) begin
            es = 1'b0; er = 1'b0; eb = '0;
            mq.delete();
            waited = 0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
         end else begin
            preq      = p_we && (p_rd != 5'd0);
            er        = (mq.size() < DEPTH);
            was_empty = (mq.size() == 0);
            drain     = !was_empty && (!preq || waited == STARVE_MAX);
            es        = drain && preq;
            eb        = '0;
            foreach (mq[k]) eb[mq[k].rd] = 1'b1;
            if (drain) begin
               m_we = 1'b1; m_addr = mq[0].rd; m_data = mq[0].data;
               void'(mq.pop_front());
            end else if (preq) begin
               m_we = 1'b1; m_addr = p_rd; m_data = p_dat;
            end else begin
               m_we = 1'b0;
            end
            if (m_v && er && m_rd != 5'd0) mq.push_back('{rd: m_rd, data: m_dat});
            if (was_empty || drain) waited = 0;
            else if (waited < STARVE_MAX) waited = waited + 1;
         end

         cyc("rand", p_we, p_rd, p_dat, m_v, m_rd, m_dat, es, er, eb, m_we, m_addr, m_data);
         p_hold = es;
         m_acc  = m_v && er;
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
